// File: rtl/seq_decoder_pkg.sv
// ---------------------------------------------------------------------------
// seq_decoder_pkg
//   Shared definitions for the registered code decoder and its expander:
//     - mode_e  : command mode encodings (one-hot, thermometer,
//                 active-low one-hot, auto-scan)
//     - state_e : control FSM encodings (idle, emit a beat, inter-beat gap)
//   No ports; imported by code_expand and seq_decoder.
// ---------------------------------------------------------------------------
package seq_decoder_pkg;

  // Command modes as carried on the 2-bit mode input.
  typedef enum logic [1:0] {
    MODE_ONEHOT   = 2'd0,
    MODE_THERM    = 2'd1,
    MODE_ONEHOT_N = 2'd2,
    MODE_SCAN     = 2'd3
  } mode_e;

  // Control FSM. Modes 0-2 never leave ST_IDLE; only a scan walks
  // through ST_EMIT / ST_GAP.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Width of the mode field, shared by every port that carries a mode.
  localparam int MODE_W = 2;

endpackage : seq_decoder_pkg

// File: rtl/seq_decoder_code_expand.sv
// ---------------------------------------------------------------------------
// code_expand
//   Purely combinational code expander shared by the command-load path and
//   the scan path of seq_decoder.
//
//   Parameters
//     SEL_W   code width; OUT_W = 1 << SEL_W is derived and not overridable
//
//   Ports
//     sel      in   SEL_W   code to expand
//     mode     in   2       mode_e encoding
//     pattern  out  OUT_W   expanded pattern
//
//   Mapping
//     MODE_ONEHOT    pattern[i] = (i == sel)
//     MODE_THERM     pattern[i] = (i <= sel)
//     MODE_ONEHOT_N  pattern    = ~one-hot
//     MODE_SCAN      one-hot (the scan path presents the beat index as sel)
// ---------------------------------------------------------------------------
module code_expand
  import seq_decoder_pkg::*;
#(
  parameter  int SEL_W = 3,
  localparam int OUT_W = 1 << SEL_W
) (
  input  logic [SEL_W-1:0]  sel,
  input  logic [MODE_W-1:0] mode,
  output logic [OUT_W-1:0]  pattern
);

  logic [OUT_W-1:0] one_hot;
  logic [OUT_W-1:0] therm;

  // Every bit position is a code value; compare it against sel.
  always_comb begin
    // NOTE: every signal written in a combinational block gets a default
    // before any conditional logic, otherwise a latch is inferred.
    one_hot = '0;
    therm   = '0;
    for (int i = 0; i < OUT_W; i++) begin
      one_hot[i] = (SEL_W'(i) == sel);
      therm[i]   = (SEL_W'(i) <= sel);
    end
  end

  always_comb begin
    pattern = one_hot;
    case (mode_e'(mode))
      MODE_THERM:    pattern = therm;
      MODE_ONEHOT_N: pattern = ~one_hot;
      default:       pattern = one_hot;  // MODE_ONEHOT and MODE_SCAN
    endcase
  end

endmodule : code_expand

// File: rtl/seq_decoder.sv
// ---------------------------------------------------------------------------
// seq_decoder
//   Registered, parametrised code decoder between a valid/ready command
//   source and LED / keypad / row-select drivers.
//
//   Modes 0-2 expand sel into a one-hot, thermometer or active-low one-hot
//   pattern with a one-deep output register (latency 1, one command per
//   cycle at full throughput). Mode 3 walks one-hot beats 0..sel, each
//   beat separated by dwell+1 cycles with out_valid low.
//
//   Parameters
//     SEL_W     code width (OUT_W = 1 << SEL_W, derived)
//     DWELL_W   width of the dwell counter
//
//   Ports
//     clk        in   1        rising-edge clock
//     rst        in   1        asynchronous active-high reset
//     in_valid   in   1        command valid
//     in_ready   out  1        command accepted when in_valid && in_ready
//     sel        in   SEL_W    code (modes 0-2) or last scan index (mode 3)
//     mode       in   2        mode_e encoding
//     dwell      in   DWELL_W  scan gap length, sampled at accept
//     out_valid  out  1        o qualified
//     out_ready  in   1        downstream accept
//     o          out  OUT_W    decoded pattern (registered)
//     scan_idx   out  SEL_W    current scan index
//     busy       out  1        high while a scan is in progress
// ---------------------------------------------------------------------------
module seq_decoder
  import seq_decoder_pkg::*;
#(
  parameter  int SEL_W   = 3,
  parameter  int DWELL_W = 8,
  localparam int OUT_W   = 1 << SEL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SEL_W-1:0]   sel,
  input  logic [MODE_W-1:0]  mode,
  input  logic [DWELL_W-1:0] dwell,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   o,
  output logic [SEL_W-1:0]   scan_idx,
  output logic               busy
);

  state_e state_q;
  state_e state_d;

  // Scan parameters captured at accept so mid-scan input changes are inert.
  logic [SEL_W-1:0]   last_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] cnt_q;

  logic accept;
  logic handshake;
  logic scan_cmd;
  logic scan_done;
  logic gap_done;

  // Expander input mux: the command path in IDLE, the next beat otherwise.
  logic [SEL_W-1:0]  exp_sel;
  logic [MODE_W-1:0] exp_mode;
  logic [OUT_W-1:0]  exp_pattern;

  assign accept    = in_valid && in_ready;
  assign handshake = out_valid && out_ready;
  assign scan_cmd  = (mode_e'(mode) == MODE_SCAN);
  assign scan_done = (scan_idx == last_q);
  assign gap_done  = (cnt_q == '0);

  code_expand #(
    .SEL_W (SEL_W)
  ) u_code_expand (
    .sel     (exp_sel),
    .mode    (exp_mode),
    .pattern (exp_pattern)
  );

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking (<=) so every register
    // samples pre-edge values; blocking here would create ordering races.
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && scan_cmd) begin
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (handshake) begin
          state_d = scan_done ? ST_IDLE : ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_done) begin
          state_d = ST_EMIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM outputs: command-side ready and expander input selection.
  // in_ready deliberately ignores in_valid to keep the handshake loop-free.
  // -------------------------------------------------------------------------
  always_comb begin
    in_ready = (state_q == ST_IDLE) && (!out_valid || out_ready);
    exp_sel  = sel;
    exp_mode = mode;
    if (state_q != ST_IDLE) begin
      // Only consumed on the GAP->EMIT edge; indices never wrap because
      // scan_idx < last_q whenever a GAP is entered.
      exp_sel  = scan_idx + SEL_W'(1);
      exp_mode = MODE_ONEHOT;
    end else if (scan_cmd) begin
      // First scan beat is always index 0.
      exp_sel  = '0;
    end
  end

  // -------------------------------------------------------------------------
  // Output registers, scan bookkeeping and dwell counter
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o         <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      scan_idx  <= '0;
      last_q    <= '0;
      dwell_q   <= '0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            // A new command overwrites a draining one in the same cycle.
            o         <= exp_pattern;
            out_valid <= 1'b1;
            if (scan_cmd) begin
              busy     <= 1'b1;
              scan_idx <= '0;
              last_q   <= sel;
              dwell_q  <= dwell;
            end
          end else if (handshake) begin
            // o keeps its last value after draining.
            out_valid <= 1'b0;
          end
        end
        ST_EMIT: begin
          if (handshake) begin
            out_valid <= 1'b0;
            if (scan_done) begin
              busy <= 1'b0;
            end else begin
              cnt_q <= dwell_q;
            end
          end
        end
        ST_GAP: begin
          // Count D..0 inclusive, so out_valid is low for D+1 cycles.
          if (gap_done) begin
            scan_idx  <= scan_idx + SEL_W'(1);
            o         <= exp_pattern;
            out_valid <= 1'b1;
          end else begin
            cnt_q <= cnt_q - DWELL_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule : seq_decoder

// File: tb/tb_seq_decoder.sv
// ---------------------------------------------------------------------------
// tb_seq_decoder
//   Scoreboard bench: the driver pushes every expected output beat when a
//   command is accepted; a monitor pops and compares on each new beat.
//   A second, SEL_W=1 instance covers the narrow build.
// ---------------------------------------------------------------------------
module tb_seq_decoder;
  import seq_decoder_pkg::*;

  localparam int SEL_W   = 3;
  localparam int DWELL_W = 8;
  localparam int OUT_W   = 1 << SEL_W;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [SEL_W-1:0]   sel;
  logic [1:0]         mode;
  logic [DWELL_W-1:0] dwell;
  logic               out_valid;
  logic               out_ready;
  logic [OUT_W-1:0]   o;
  logic [SEL_W-1:0]   scan_idx;
  logic               busy;

  // Narrow build
  logic               s_in_valid;
  logic               s_in_ready;
  logic [0:0]         s_sel;
  logic [1:0]         s_mode;
  logic [DWELL_W-1:0] s_dwell;
  logic               s_out_valid;
  logic               s_out_ready;
  logic [1:0]         s_o;
  logic [0:0]         s_scan_idx;
  logic               s_busy;

  always #5 clk = ~clk;

  seq_decoder #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .mode(mode), .dwell(dwell), .out_valid(out_valid),
    .out_ready(out_ready), .o(o), .scan_idx(scan_idx), .busy(busy)
  );

  seq_decoder #(.SEL_W(1), .DWELL_W(DWELL_W)) dut_w1 (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .sel(s_sel), .mode(s_mode), .dwell(s_dwell), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .o(s_o), .scan_idx(s_scan_idx), .busy(s_busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    logic [OUT_W-1:0] pat;
    int               gap;   // required low cycles before this beat, -1 = any
    int               idx;   // required scan_idx, -1 = any
    bit               last;  // final beat of a scan
  } beat_t;

  beat_t exp_q[$];
  bit    scan_active = 1'b0;
  bit    rand_rdy    = 1'b0;

  function automatic logic [OUT_W-1:0] ref_pattern(input int m, input int s);
    case (m)
      0:       return OUT_W'(1 << s);
      1:       return OUT_W'((1 << (s + 1)) - 1);
      2:       return OUT_W'(~(1 << s));
      default: return '0;
    endcase
  endfunction

  function automatic void push_expected(input int m, input int s, input int d);
    beat_t b;
    if (m == 3) begin
      for (int k = 0; k <= s; k++) begin
        b.pat  = OUT_W'(1 << k);
        b.gap  = (k == 0) ? -1 : d + 1;
        b.idx  = k;
        b.last = (k == s);
        exp_q.push_back(b);
      end
    end else begin
      b.pat  = ref_pattern(m, s);
      b.gap  = -1;
      b.idx  = -1;
      b.last = 1'b0;
      exp_q.push_back(b);
    end
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic send(input int m, input int s, input int d);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    mode     = 2'(m);
    sel      = SEL_W'(s);
    dwell    = DWELL_W'(d);
    for (int n = 0; n < 500 && !ok; n++) begin
      @(negedge clk);
      if (in_ready) begin
        push_expected(m, s, d);
        ok = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) check("accept_timeout", 0, 1);
    else if (m == 3) scan_active = 1'b1;
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 2000 && !done; n++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && !scan_active && !out_valid;
    end
    if (!done) check("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset_now();
    rst = 1'b1;
    #1;
    check("rst_o", o, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    exp_q.delete();
    scan_active = 1'b0;
  endtask

  // ---------------- random out_ready ----------------
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- monitor ----------------
  initial begin
    bit               prev_stall = 1'b0;
    logic [OUT_W-1:0] prev_o     = '0;
    int               low_cnt    = 0;
    bit               cur_last   = 1'b0;
    beat_t            b;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        low_cnt    = 0;
        cur_last   = 1'b0;
        continue;
      end
      check("busy", busy, scan_active);
      if (scan_active) check("in_ready_mid_scan", in_ready, 0);
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_o", o, prev_o);
      end else if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", o, 0);
          cur_last = 1'b0;
        end else begin
          b = exp_q.pop_front();
          check("beat_o", o, b.pat);
          if (b.gap >= 0) check("beat_gap", low_cnt, b.gap);
          if (b.idx >= 0) check("beat_scan_idx", scan_idx, b.idx);
          cur_last = b.last;
        end
        low_cnt = 0;
      end
      if (!out_valid) low_cnt++;
      if (out_valid && out_ready) begin
        if (cur_last) scan_active = 1'b0;
        cur_last = 1'b0;
      end
      prev_stall = out_valid && !out_ready;
      prev_o     = o;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    bit found;
    rst = 1'b1; in_valid = 1'b0; sel = '0; mode = '0; dwell = '0; out_ready = 1'b1;
    s_in_valid = 1'b0; s_sel = '0; s_mode = '0; s_dwell = '0; s_out_ready = 1'b1;
    #1;
    check("reset_o", o, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_scan_idx", scan_idx, 0);
    check("reset_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;

    // Async reset in the middle of a stall.
    out_ready = 1'b0;
    send(0, 1, 0);
    @(posedge clk);
    #3;
    do_reset_now();
    @(posedge clk);
    #3 rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back one-hot at full throughput.
    send(0, 5, 0);
    send(0, 0, 0);
    send(0, 7, 0);
    wait_drain();

    // Thermometer, then active-low one-hot held by a 3-cycle stall.
    send(1, 3, 0);
    send(2, 2, 0);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 0);
      check("stall_o", o, 8'hFB);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("stall_drained", out_valid, 0);
    @(posedge clk);
    #1;

    // Scan 0..3 with dwell 2.
    send(3, 3, 2);
    wait_drain();

    // Single-beat scan.
    send(3, 0, 5);
    wait_drain();

    // Scan 0..7, stall beat 2 for 5 cycles, reset during the following gap.
    send(3, 7, 3);
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      @(negedge clk);
      found = out_valid && (o == 8'h02);
    end
    if (!found) check("scan_beat1_timeout", 0, 1);
    @(posedge clk);
    #1 out_ready = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      @(negedge clk);
      found = out_valid && (o == 8'h04);
    end
    if (!found) check("scan_beat2_timeout", 0, 1);
    repeat (4) @(negedge clk);
    check("scan_stall_o", o, 8'h04);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #3;
    do_reset_now();
    @(posedge clk);
    #3 rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;

    // Randomized traffic against the model.
    rand_rdy = 1'b1;
    for (int t = 0; t < 60; t++) begin
      send($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) begin
        mode = 2'($urandom);
        sel  = SEL_W'($urandom);
        @(posedge clk);
        #1;
      end
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    wait_drain();
    check("final_queue_empty", exp_q.size(), 0);

    // SEL_W=1 build.
    s_in_valid = 1'b1; s_mode = 2'd1; s_sel = 1'b1;
    @(posedge clk);
    #1;
    check("w1_therm", s_o, 2'b11);
    check("w1_valid", s_out_valid, 1);
    s_mode = 2'd2; s_sel = 1'b0;
    @(posedge clk);
    #1;
    check("w1_onehot_n", s_o, 2'b10);
    s_in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("w1_drained", s_out_valid, 0);
    check("w1_busy", s_busy, 0);
    check("w1_scan_idx", s_scan_idx, 0);
    check("w1_in_ready", s_in_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_seq_decoder
